// File: rtl/fp_add_tree_if.sv
// fp_add_tree_if: lane data, tag and valid going in; sum, tag, exception and busy coming out.
// master drives the operands, slave is the adder tree.
interface fp_add_tree_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned TAG_W  = 8
);
  logic                  in_valid;
  logic [NUM_IN*32-1:0]  in_data;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic [31:0]           out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_exc;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_tag,
    input  out_valid, out_data, out_tag, out_exc, busy
  );

  modport slave (
    input  in_valid, in_data, in_tag,
    output out_valid, out_data, out_tag, out_exc, busy
  );
endinterface

// File: rtl/fp_add_tree.sv
// fp_add_tree: pipelined FP32 reduction of NUM_IN lanes through a balanced tree of FP_ADD cores.
// Define FP_ADD_TREE_EXC_EN to flag Inf/NaN inputs on out_exc; otherwise out_exc is tied low.

module FP_ADD #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  logic [31:0] w_big, w_sml, w_sum, w_pack;
  logic        w_swap, w_sub, w_nan, w_inf, w_rnd, w_stk, w_lzfound;
  logic [8:0]  w_ebig, w_esml, w_d, w_eres;
  logic [26:0] w_mbig, w_msml, w_mshf, w_mnorm;
  logic [27:0] w_msum;
  logic [4:0]  w_lz, w_sh;
  logic [31:0] r_pipe [LATENCY];

  always_comb begin
    w_swap = b[30:0] > a[30:0];
    w_big  = w_swap ? b : a;
    w_sml  = w_swap ? a : b;
    w_ebig = (w_big[30:23] == 8'd0) ? 9'd1 : {1'b0, w_big[30:23]};
    w_esml = (w_sml[30:23] == 8'd0) ? 9'd1 : {1'b0, w_sml[30:23]};
    // 24-bit significand plus guard, round and sticky positions
    w_mbig = {|w_big[30:23], w_big[22:0], 3'b000};
    w_msml = {|w_sml[30:23], w_sml[22:0], 3'b000};
    w_d    = w_ebig - w_esml;
    w_sub  = w_big[31] ^ w_sml[31];
    w_stk  = 1'b0;
    if (w_d > 9'd26) begin
      w_mshf = {26'd0, |w_msml};
    end else begin
      w_mshf    = w_msml >> w_d[4:0];
      w_stk     = |(w_msml & ~({27{1'b1}} << w_d[4:0]));
      w_mshf[0] = w_mshf[0] | w_stk;
    end
    w_msum = w_sub ? ({1'b0, w_mbig} - {1'b0, w_mshf}) : ({1'b0, w_mbig} + {1'b0, w_mshf});

    w_lz      = 5'd0;
    w_lzfound = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!w_lzfound && w_msum[26-i]) begin
        w_lzfound = 1'b1;
        w_lz      = 5'(i);
      end
    end

    if (w_msum[27]) begin
      w_sh    = 5'd0;
      w_mnorm = {w_msum[27:2], w_msum[1] | w_msum[0]};
      w_eres  = w_ebig + 9'd1;
    end else begin
      // left shift stops at the minimum exponent so tiny results stay subnormal
      w_sh    = ({4'd0, w_lz} < w_ebig) ? w_lz : 5'(w_ebig - 9'd1);
      w_mnorm = w_msum[26:0] << w_sh;
      w_eres  = w_mnorm[26] ? (w_ebig - {4'd0, w_sh}) : 9'd0;
    end

    // round-to-nearest-even; the carry ripples into the exponent field
    w_rnd  = w_mnorm[2] & (w_mnorm[1] | w_mnorm[0] | w_mnorm[3]);
    w_pack = {w_eres, w_mnorm[25:3]} + {31'd0, w_rnd};

    w_nan = ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) ||
            ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0)) ||
            ((a[30:23] == 8'hFF) && (b[30:23] == 8'hFF) && (a[31] != b[31]));
    w_inf = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);

    if (w_nan)                       w_sum = 32'h7FC0_0000;
    else if (w_inf)                  w_sum = w_big;
    else if (w_msum == 28'd0)        w_sum = {~w_sub & w_big[31], 31'd0};
    else if (w_pack[31:23] >= 9'd255) w_sum = {w_big[31], 8'hFF, 23'd0};
    else                             w_sum = {w_big[31], w_pack[30:0]};
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      for (int unsigned i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_sum;
      for (int unsigned i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign q = r_pipe[LATENCY-1];
endmodule

module fp_add_tree #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned ADD_LATENCY = 3,
  parameter int unsigned TAG_W       = 8
) (
  input logic          clk,
  input logic          reset,
  fp_add_tree_if.slave bus
);
  localparam int unsigned LEVELS = $clog2(NUM_IN);
  localparam int unsigned LAT    = LEVELS * ADD_LATENCY;

  function automatic int unsigned lvl_cnt(input int unsigned l);
    return (NUM_IN + (32'd1 << l) - 32'd1) >> l;
  endfunction

  function automatic int unsigned lvl_off(input int unsigned l);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < l; j++) off += lvl_cnt(j);
    return off;
  endfunction

  localparam int unsigned N_NODES = lvl_off(LEVELS + 1);

  // every tree element at every level, flattened level by level
  logic [31:0]      w_node [N_NODES];
  logic             r_vld  [LAT];
  logic [TAG_W-1:0] r_tag  [LAT];
  logic             r_busy;
  logic             w_any_vld;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign w_node[i] = bus.in_data[32*i +: 32];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar k = 0; k < lvl_cnt(l + 1); k++) begin : g_node
      localparam int unsigned SRC = lvl_off(l) + 2 * k;
      localparam int unsigned DST = lvl_off(l + 1) + k;
      if (2 * k + 1 < lvl_cnt(l)) begin : g_add
        FP_ADD #(.LATENCY(ADD_LATENCY)) u_add (
          .clk    (clk),
          .areset (reset),
          .a      (w_node[SRC]),
          .b      (w_node[SRC+1]),
          .q      (w_node[DST])
        );
      end else begin : g_byp
        logic [31:0] r_byp [ADD_LATENCY];
        always_ff @(posedge clk) begin
          r_byp[0] <= w_node[SRC];
          for (int unsigned i = 1; i < ADD_LATENCY; i++) r_byp[i] <= r_byp[i-1];
        end
        assign w_node[DST] = r_byp[ADD_LATENCY-1];
      end
    end
  end

  always_comb begin
    w_any_vld = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) w_any_vld = w_any_vld | r_vld[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
      end
      r_busy <= 1'b0;
    end else begin
      r_vld[0] <= bus.in_valid;
      r_tag[0] <= bus.in_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      r_busy <= bus.in_valid | w_any_vld;
    end
  end

  assign bus.out_valid = r_vld[LAT-1];
  assign bus.out_tag   = r_tag[LAT-1];
  assign bus.out_data  = w_node[N_NODES-1];
  assign bus.busy      = r_busy;

`ifdef FP_ADD_TREE_EXC_EN
  logic w_exc_in;
  logic r_exc [LAT];

  always_comb begin
    w_exc_in = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.in_data[32*i+23 +: 8] == 8'hFF) w_exc_in = 1'b1;
    end
    w_exc_in = w_exc_in & bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) r_exc[i] <= 1'b0;
    end else begin
      r_exc[0] <= w_exc_in;
      for (int unsigned i = 1; i < LAT; i++) r_exc[i] <= r_exc[i-1];
    end
  end

  assign bus.out_exc = r_exc[LAT-1] & r_vld[LAT-1];
`else
  assign bus.out_exc = 1'b0;
`endif
endmodule

// File: doc/fp_add_tree.md
# fp_add_tree

Parametrised, fully pipelined single-precision floating-point adder tree. Sums `NUM_IN` IEEE-754 lanes per cycle by instantiating `FP_ADD` cores in a balanced binary tree. Odd lanes are carried through delay-matched bypass registers. A valid/tag sideband runs alongside the data so results can be matched to their inputs. It is the generalised successor to the fixed four-input adder and sits in the datapath wherever dot products or reductions are formed.

## Interface
- `NUM_IN`, 4: number of input lanes, 2..64, need not be a power of two.
- `ADD_LATENCY`, 3: pipeline depth of one `FP_ADD` core in cycles, 1..16; must match the generated core.
- `TAG_W`, 8: width of the user tag carried with each operation, 1..32.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high; also drives the `areset` pin of every `FP_ADD` core.
- `in_valid` in 1: lane data is valid this cycle.
- `in_data` in `NUM_IN*32`: lane i occupies bits [32i+31:32i].
- `in_tag` in `TAG_W`: tag accompanying `in_data`.
- `out_valid` out 1: `out_data` holds a completed sum.
- `out_data` out 32: sum of all lanes.
- `out_tag` out `TAG_W`: tag of the operation on `out_data`.
- `out_exc` out 1: input exception flag (see Configuration).
- `busy` out 1: at least one valid operation is in flight.

## Operation
- `LEVELS` = ceil(log2(`NUM_IN`)).
- Level 0 operands are the input lanes. At level l, element 2k+1 is added to element 2k by one `FP_ADD`. The result becomes element k of level l+1.
- If a level has an odd element count, its last element is not added. It passes to the next level through an `ADD_LATENCY`-deep register chain so it stays aligned with the adder outputs.
- The summation order is therefore fixed and deterministic. The bench model must use the same pairing, because FP addition is not associative.
- No backpressure: a new operation can enter every cycle and the pipeline never stalls.
- `in_valid`=0 cycles still clock data through the cores. Those results are flagged invalid.
- Valid pipeline: a shift register `LEVELS*ADD_LATENCY` deep carries `in_valid`, and a parallel register chain carries `in_tag`. `out_valid` and `out_tag` are the final stage of these chains.
- `busy` = OR of all valid-pipeline stages, including the input stage. It is registered, so it reflects stages as of the previous edge.
- Arithmetic (rounding, denormals, NaN propagation) is whatever `FP_ADD` produces. This block adds no arithmetic of its own.

## Timing
- Latency L = `LEVELS*ADD_LATENCY` cycles. `in_valid` sampled at edge n produces `out_valid`=1 after edge n+L. Example: `NUM_IN`=4, `ADD_LATENCY`=3 gives L=6; `NUM_IN`=5 gives L=9.
- Throughput is one operation per cycle. Back-to-back inputs produce back-to-back outputs, in order, with tags unchanged.
- Reset values: `out_valid`=0, `out_tag`=0, `out_exc`=0, `busy`=0, and all valid, tag and exception stages are 0. `out_data` and bypass data registers are not reset. `out_data` is don't-care while `out_valid`=0.
- Reset mid-operation: every in-flight operation is discarded. `out_valid`=0 from the first edge with `reset`=1 until L edges after the first valid input following reset release.
- Inputs presented while `reset`=1 are dropped.
- `NUM_IN`=2 degenerates to a single `FP_ADD` with L=`ADD_LATENCY`.

## Configuration
- `FP_ADD_TREE_EXC_EN` defined: at the input, `exc` = `in_valid` AND (any lane has exponent field 8'hFF, i.e. Inf or NaN). `exc` travels through an L-deep chain and appears on `out_exc` with `out_valid`. It is forced 0 when `out_valid`=0.
- Macro undefined: `out_exc` is tied to 0 and no detection or chain logic is built. The port remains present.

## Test plan
- `NUM_IN`=4, `ADD_LATENCY`=3: in_data lanes {1.0, 2.0, 3.0, 4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000), tag 0x5A → exactly 6 cycles later `out_valid`=1, `out_data`=0x41200000 (10.0), `out_tag`=0x5A.
- `NUM_IN`=5: lanes 1.0..5.0 → after 9 cycles `out_data`=0x41700000 (15.0). This checks bypass alignment of lane 4.
- Streaming: 20 consecutive valid vectors, lanes all equal to tag value k (k=1..20) with `NUM_IN`=4 → 20 consecutive outputs equal to 4k in order with matching tags. `busy` stays 1 throughout and drops 1 cycle after the last `out_valid`.
- Reset mid-flight: three valid inputs, then `reset` asserted for 1 cycle 2 cycles later → no `out_valid` ever appears for them. A subsequent input is summed correctly with latency L.
- With `FP_ADD_TREE_EXC_EN`: lane 2 = 0x7FC00000, others 1.0 → `out_exc`=1 with `out_valid`. The next vector, all 1.0 lanes, gives `out_exc`=0 and `out_data`=0x40800000.
